// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester round-robin arbiter in front of a single memory port.
//   Requester 0 is instruction fetch and requester 1 is load/store.
//   Each grant holds the port until mem_ready arrives or a wait timeout expires.
//   At least one IDLE cycle always separates two grants.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req0/1, addr0/1, wdata0/1, we0/1
//                              per-requester access request and payload
//   gnt0/1                     grant status (one-hot or zero)
//   sel                        shared mux select (0 = req 0, 1 = req 1)
//   mem_valid/addr/wdata/we    shared memory port
//   mem_ready, mem_rdata       memory completion and read data
//   done0/1, err0/1            completion / timeout-abort pulses
//   rdata                      mem_rdata passed straight through

// Per-requester status decode: turns "this lane owns the port" into
// grant, completion and timeout pulses.
module mem_port_arbiter_lane (
  input  logic granted,
  input  logic mem_ready,
  input  logic timeout_hit,
  output logic gnt,
  output logic done,
  output logic err
);
  assign gnt  = granted;
  assign done = granted & mem_ready;
  // A ready in the timeout cycle wins: completion, not abort.
  assign err  = granted & ~mem_ready & timeout_hit;
endmodule

module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata
);
  localparam int NUM_LANES = 2;
  // cnt only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

  state_t           state, state_n;
  logic             last;
  logic             sel_q;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             win;
  logic             busy;
  logic             timeout_hit;

  req_t [NUM_LANES-1:0] reqs;
  req_t                 cur;
  logic [NUM_LANES-1:0] lane_granted, lane_gnt, lane_done, lane_err;

  assign reqs[0] = '{addr: addr0, wdata: wdata0, we: we0};
  assign reqs[1] = '{addr: addr1, wdata: wdata1, we: we1};
  assign cur     = reqs[sel_q];

  assign busy        = (state != IDLE);
  assign timeout_hit = (cnt == CNT_LAST);

  // Next state. In IDLE a tie goes to the requester that did not win last.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    win     = sel_q;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant   = 1'b1;
          win     = (req0 & req1) ? ~last : req1;
          state_n = win ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        // Always return through IDLE; no BUSY-to-BUSY handoff.
        if (mem_ready || timeout_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;   // requester 0 wins the first tie
      sel_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        last  <= win;
        sel_q <= win;
        cnt   <= '0;
      end else if (busy && !mem_ready && !timeout_hit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign lane_granted = {state == BUSY1, state == BUSY0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_port_arbiter_lane u_lane (
      .granted     (lane_granted[i]),
      .mem_ready   (mem_ready),
      .timeout_hit (timeout_hit),
      .gnt         (lane_gnt[i]),
      .done        (lane_done[i]),
      .err         (lane_err[i])
    );
  end

  assign gnt0  = lane_gnt[0];
  assign gnt1  = lane_gnt[1];
  assign done0 = lane_done[0];
  assign done1 = lane_done[1];
  assign err0  = lane_err[0];
  assign err1  = lane_err[1];

  // sel is a register, so it holds the last owner through IDLE and
  // already points at the new owner in the first BUSY cycle.
  assign sel       = sel_q;
  assign mem_valid = busy;
  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;
  assign mem_we    = busy & cur.we;
  assign rdata     = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, mem_ready;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        gnt0, gnt1, sel, mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        done0, done1, err0, err1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata)
  );

  typedef struct {
    logic        rst, r0, r1, we0, we1, rdy;
    logic [31:0] a0, a1, wd0, wd1;
    logic        g0, g1, sel, mv, mwe;
    logic [31:0] maddr, mwd;
    logic        d0, d1, e0, e1;
  } vec_t;

  localparam int NV = 28;
  vec_t v [NV];

  function automatic vec_t mk(
    input logic rst_i, r0, r1, w0, w1, rdy,
    input logic [31:0] a0, a1, wd0, wd1,
    input logic g0, g1, s, mv, mwe,
    input logic [31:0] maddr, mwd,
    input logic d0, d1, e0, e1);
    vec_t t;
    t.rst = rst_i; t.r0 = r0; t.r1 = r1; t.we0 = w0; t.we1 = w1; t.rdy = rdy;
    t.a0 = a0; t.a1 = a1; t.wd0 = wd0; t.wd1 = wd1;
    t.g0 = g0; t.g1 = g1; t.sel = s; t.mv = mv; t.mwe = mwe;
    t.maddr = maddr; t.mwd = mwd;
    t.d0 = d0; t.d1 = d1; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  // Single-bit check used by the hand-written sequences.
  task automatic chk(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ready = 0;
  endtask

  initial begin
    logic [9:0]  got_c, exp_c;
    logic [95:0] got_d, exp_d;

    rst = 1; idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;

    //            rst r0 r1 w0 w1 rdy a0        a1        wd0       wd1       g0 g1 s mv we maddr     mwd       d0 d1 e0 e1
    // single fetch, immediate ready
    v[0]  = mk(1, 0,0,0,0,0, 32'h0,   32'h0,   32'h0,  32'h0,  0,0,0,0,0, 32'h0,   32'h0,  0,0,0,0);
    v[1]  = mk(0, 1,0,0,0,0, 32'h2,   32'h0,   32'h11, 32'h0,  0,0,0,0,0, 32'h2,   32'h11, 0,0,0,0);
    v[2]  = mk(0, 1,0,0,0,1, 32'h2,   32'h0,   32'h11, 32'h0,  1,0,0,1,0, 32'h2,   32'h11, 1,0,0,0);
    v[3]  = mk(0, 0,0,0,0,0, 32'h0,   32'h0,   32'h0,  32'h0,  0,0,0,0,0, 32'h0,   32'h0,  0,0,0,0);
    // load/store write, one wait cycle; sel held at 1 in following IDLE
    v[4]  = mk(0, 0,1,0,1,0, 32'h44,  32'h10,  32'h55, 32'h3,  0,0,0,0,0, 32'h44,  32'h55, 0,0,0,0);
    v[5]  = mk(0, 0,1,0,1,0, 32'h44,  32'h10,  32'h55, 32'h3,  0,1,1,1,1, 32'h10,  32'h3,  0,0,0,0);
    v[6]  = mk(0, 0,1,0,1,1, 32'h44,  32'h10,  32'h55, 32'h3,  0,1,1,1,1, 32'h10,  32'h3,  0,1,0,0);
    v[7]  = mk(0, 0,0,0,1,0, 32'h44,  32'h10,  32'h55, 32'h3,  0,0,1,0,0, 32'h10,  32'h3,  0,0,0,0);
    // reset, then both requesting: 0,1,0,1 with IDLE between
    v[8]  = mk(1, 1,1,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[9]  = mk(0, 1,1,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[10] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  1,0,0,1,0, 32'h100, 32'hA,  1,0,0,0);
    v[11] = mk(0, 1,1,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[12] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  0,1,1,1,0, 32'h200, 32'hB,  0,1,0,0);
    v[13] = mk(0, 1,1,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,1,0,0, 32'h200, 32'hB,  0,0,0,0);
    v[14] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  1,0,0,1,0, 32'h100, 32'hA,  1,0,0,0);
    v[15] = mk(0, 1,1,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[16] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  0,1,1,1,0, 32'h200, 32'hB,  0,1,0,0);
    v[17] = mk(0, 0,0,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,1,0,0, 32'h200, 32'hB,  0,0,0,0);
    // reset during BUSY1: async drop, no done1, next tie goes to 0
    v[18] = mk(0, 0,1,0,1,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,1,0,0, 32'h200, 32'hB,  0,0,0,0);
    v[19] = mk(0, 0,1,0,1,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,1,1,1,1, 32'h200, 32'hB,  0,0,0,0);
    v[20] = mk(1, 0,1,0,1,1, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[21] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[22] = mk(0, 1,1,0,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  1,0,0,1,0, 32'h100, 32'hA,  1,0,0,0);
    v[23] = mk(0, 0,0,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    // req dropped mid-BUSY does not abort
    v[24] = mk(0, 1,0,1,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);
    v[25] = mk(0, 0,0,1,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  1,0,0,1,1, 32'h100, 32'hA,  0,0,0,0);
    v[26] = mk(0, 0,0,1,0,1, 32'h100, 32'h200, 32'hA,  32'hB,  1,0,0,1,1, 32'h100, 32'hA,  1,0,0,0);
    v[27] = mk(0, 0,0,0,0,0, 32'h100, 32'h200, 32'hA,  32'hB,  0,0,0,0,0, 32'h100, 32'hA,  0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = v[i].rst; req0 = v[i].r0; req1 = v[i].r1;
      we0 = v[i].we0; we1 = v[i].we1; mem_ready = v[i].rdy;
      addr0 = v[i].a0; addr1 = v[i].a1; wdata0 = v[i].wd0; wdata1 = v[i].wd1;
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      #1;
      got_c = {gnt0, gnt1, sel, mem_valid, mem_we, done0, done1, err0, err1, 1'b0};
      exp_c = {v[i].g0, v[i].g1, v[i].sel, v[i].mv, v[i].mwe,
               v[i].d0, v[i].d1, v[i].e0, v[i].e1, 1'b0};
      got_d = {mem_addr, mem_wdata, rdata};
      exp_d = {v[i].maddr, v[i].mwd, 32'hC0DE_0000 + 32'(i)};
      tests++;
      if (got_c !== exp_c || got_d !== exp_d) begin
        failed++;
        $display("FAIL vec%0d: got ctl=%b data=%h expected ctl=%b data=%h",
                 i, got_c, got_d, exp_c, exp_d);
      end
    end

    // Timeout: ready never comes; err0 in the 15th BUSY cycle only.
    @(negedge clk);
    idle_inputs(); req0 = 1; addr0 = 32'h7;
    #1 chk("to_idle_gnt", gnt0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to_gnt0_c%0d", k), gnt0, 1'b1);
      chk($sformatf("to_done0_c%0d", k), done0, 1'b0);
      chk($sformatf("to_err0_c%0d", k), err0, (k == 15));
    end
    req0 = 0;
    @(negedge clk); #1;
    chk("to_after_valid", mem_valid, 1'b0);
    chk("to_after_err0", err0, 1'b0);

    // Ready arrives exactly in the timeout cycle: completion wins.
    @(negedge clk);
    req0 = 1; #1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      mem_ready = (k == 15);
      #1;
      chk($sformatf("rt_err0_c%0d", k), err0, 1'b0);
      chk($sformatf("rt_done0_c%0d", k), done0, (k == 15));
    end
    req0 = 0; mem_ready = 0;
    @(negedge clk); #1;
    chk("rt_after_valid", mem_valid, 1'b0);
    chk("rt_after_done0", done0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
